// File: rtl/qspi_xfer_engine.sv
// rtl/qspi_xfer_engine.sv - QSPI mode-0 transfer engine: command, address, dummy and 1/2/4-lane data phases
module qspi_xfer_engine #(
  parameter int DIV_W = 8,
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [7:0]       cmd_i,
  input  logic             addr_en_i,
  input  logic [23:0]      addr_i,
  input  logic [3:0]       dummy_i,
  input  logic [1:0]       mode_i,
  input  logic             dir_i,
  input  logic [LEN_W-1:0] nbytes_i,
  input  logic [DIV_W-1:0] clkdiv_i,
  input  logic [7:0]       tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  output logic             busy_o,
  output logic             done_o,
  input  logic [3:0]       qspi_i,
  output logic [3:0]       qspi_o,
  output logic [3:0]       qspi_oe_o,
  output logic             qspi_csb_o,
  output logic             qspi_sclk_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CSSU, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_CSH, S_DESEL
  } state_e;

  state_e state_q, state_d, after_addr, after_dummy;

  logic             addr_en_q, dir_q, sclk_q, have_byte_q, rx_valid_q, done_q;
  logic [3:0]       dummy_q;
  logic [1:0]       mode_q;
  logic [LEN_W-1:0] byte_cnt_q;
  logic [DIV_W-1:0] div_q, div_cnt_q;
  logic [4:0]       bit_cnt_q, last_idx, cyc_per_byte;
  logic [31:0]      sr_q;
  logic [7:0]       rx_sr_q, rx_next;
  logic [3:0]       lanes;
  logic             quad, dual, wr_stall, run, tick, clk_ph, rise, fall, last_cyc, hs;

  // Lane decode; the reserved mode falls back to single lane
  assign quad         = (mode_q == 2'd2);
  assign dual         = (mode_q == 2'd1);
  assign lanes        = quad ? 4'b1111 : (dual ? 4'b0011 : 4'b0001);
  assign cyc_per_byte = quad ? 5'd2 : (dual ? 5'd4 : 5'd8);

  // A write byte boundary without a byte in hand freezes the half-period counter
  assign wr_stall   = (state_q == S_DATA) && dir_q && !have_byte_q;
  assign run        = (state_q != S_IDLE) && !wr_stall;
  assign tick       = run && (div_cnt_q == div_q);
  assign clk_ph     = state_q inside {S_CMD, S_ADDR, S_DUMMY, S_DATA};
  assign rise       = tick && clk_ph && !sclk_q;
  assign fall       = tick && clk_ph && sclk_q;
  assign hs         = wr_stall && tx_valid_i;
  assign last_cyc   = (bit_cnt_q == last_idx);

  assign tx_ready_o  = hs;
  assign rx_data_o   = rx_sr_q;
  assign rx_valid_o  = rx_valid_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != S_IDLE);
  assign qspi_sclk_o = sclk_q;

  // Index of the final SCLK cycle of the current phase (or byte in DATA)
  always_comb begin
    last_idx = 5'd7;
    case (state_q)
      S_ADDR:  last_idx = 5'd23;
      S_DUMMY: last_idx = {1'b0, dummy_q} - 5'd1;
      S_DATA:  last_idx = cyc_per_byte - 5'd1;
      default: last_idx = 5'd7;
    endcase
  end

  // Read shift: single lane listens on IO1, dual on IO1:0, quad on IO3:0
  always_comb begin
    rx_next = {rx_sr_q[6:0], qspi_i[1]};
    if (quad)      rx_next = {rx_sr_q[3:0], qspi_i};
    else if (dual) rx_next = {rx_sr_q[5:0], qspi_i[1:0]};
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and pad drive
  always_comb begin
    after_dummy = (byte_cnt_q != '0) ? S_DATA : S_CSH;
    after_addr  = (dummy_q != 4'd0) ? S_DUMMY : after_dummy;
    state_d     = state_q;
    qspi_o      = 4'b0000;
    qspi_oe_o   = 4'b0000;
    qspi_csb_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        qspi_csb_o = 1'b1;
        if (start_i && !done_q) state_d = S_CSSU;
      end
      S_CSSU: begin
        qspi_o    = {3'b000, sr_q[31]};
        qspi_oe_o = 4'b0001;
        if (tick) state_d = S_CMD;
      end
      S_CMD: begin
        qspi_o    = {3'b000, sr_q[31]};
        qspi_oe_o = 4'b0001;
        if (fall && last_cyc) state_d = addr_en_q ? S_ADDR : after_addr;
      end
      S_ADDR: begin
        qspi_o    = {3'b000, sr_q[31]};
        qspi_oe_o = 4'b0001;
        if (fall && last_cyc) state_d = after_addr;
      end
      S_DUMMY: begin
        if (fall && last_cyc) state_d = after_dummy;
      end
      S_DATA: begin
        if (dir_q) begin
          qspi_oe_o = lanes;
          qspi_o    = quad ? sr_q[31:28] : (dual ? {2'b00, sr_q[31:30]} : {3'b000, sr_q[31]});
        end
        if (fall && last_cyc && (byte_cnt_q == LEN_W'(1))) state_d = S_CSH;
      end
      S_CSH: begin
        if (tick) state_d = S_DESEL;
      end
      S_DESEL: begin
        qspi_csb_o = 1'b1;
        if (tick && bit_cnt_q[0]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Transaction latch, SCLK generation, shifting and byte handshakes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_en_q   <= 1'b0;
      dir_q       <= 1'b0;
      sclk_q      <= 1'b0;
      have_byte_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      dummy_q     <= '0;
      mode_q      <= '0;
      byte_cnt_q  <= '0;
      div_q       <= '0;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      rx_sr_q     <= '0;
    end else begin
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (start_i && !done_q) begin
          addr_en_q   <= addr_en_i;
          dummy_q     <= dummy_i;
          mode_q      <= mode_i;
          dir_q       <= dir_i;
          byte_cnt_q  <= nbytes_i;
          div_q       <= clkdiv_i;
          sr_q        <= {cmd_i, addr_i};
          div_cnt_q   <= '0;
          bit_cnt_q   <= '0;
          sclk_q      <= 1'b0;
          have_byte_q <= 1'b0;
          rx_sr_q     <= '0;
        end
      end else begin
        div_cnt_q <= (tick || !run) ? '0 : div_cnt_q + 1'b1;
        if (rise) begin
          sclk_q <= 1'b1;
          if (state_q == S_DATA && !dir_q) begin
            rx_sr_q <= rx_next;
            if (last_cyc) rx_valid_q <= 1'b1;
          end
        end
        if (fall) begin
          sclk_q    <= 1'b0;
          bit_cnt_q <= last_cyc ? 5'd0 : bit_cnt_q + 5'd1;
          if (state_q == S_DATA) begin
            sr_q <= quad ? (sr_q << 4) : (dual ? (sr_q << 2) : (sr_q << 1));
            if (last_cyc) begin
              have_byte_q <= 1'b0;
              byte_cnt_q  <= byte_cnt_q - LEN_W'(1);
            end
          end else begin
            sr_q <= sr_q << 1;
          end
        end
        if (hs) begin
          sr_q        <= {tx_data_i, 24'h000000};
          have_byte_q <= 1'b1;
        end
        if (state_q == S_DESEL && tick) begin
          bit_cnt_q <= bit_cnt_q + 5'd1;
          if (bit_cnt_q[0]) done_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/qspi_xfer_engine.md
Name: qspi_xfer_engine

Overview:
Serial transfer engine directly downstream of the QSPI flash controller top. The controller's register/command logic issues one transaction per start pulse, giving command, address, dummy count, lane mode, direction, byte count and clock divider. The engine sequences CSB/SCLK/IO pads in SPI mode 0: command, optional 24-bit address, dummy cycles, then a data phase in 1/2/4-lane mode. Write data and read data move through per-byte streams.

Parameters:
DIV_W, 8, width of clock divider input
LEN_W, 16, width of byte-count input

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  transaction request pulse; ignored unless idle
cmd_i  in  8  command opcode
addr_en_i  in  1  1 = send address phase
addr_i  in  24  flash address
dummy_i  in  4  dummy SCLK cycles (0-15)
mode_i  in  2  data lanes: 0 = single, 1 = dual, 2 = quad, 3 = reserved (treated as single)
dir_i  in  1  0 = read data phase, 1 = write data phase
nbytes_i  in  LEN_W  data bytes; 0 = no data phase
clkdiv_i  in  DIV_W  SCLK half-period = clkdiv_i+1 clk cycles
tx_data_i  in  8  write byte
tx_valid_i  in  1  write byte available
tx_ready_o  out  1  write byte accepted this cycle
rx_data_o  out  8  read byte
rx_valid_o  out  1  1-cycle strobe, rx_data_o valid
busy_o  out  1  transaction in progress
done_o  out  1  1-cycle pulse at transaction end
qspi_i  in  4  pad inputs IO3..IO0
qspi_o  out  4  pad outputs
qspi_oe_o  out  4  pad output enables
qspi_csb_o  out  1  chip select, active low
qspi_sclk_o  out  1  serial clock

Behaviour:
- Reset (async, immediate, including mid-transaction): csb=1, sclk=0, qspi_o=0, qspi_oe_o=0, busy/done/tx_ready/rx_valid=0, FSM=IDLE. No partial-byte flush.
- start_i in IDLE latches all transaction inputs and clkdiv_i; busy_o=1 from the next cycle. start_i while busy: ignored.
- Half-period counter counts 0..clkdiv; "tick" on terminal count. SCLK toggles only on ticks inside CMD/ADDR/DUMMY/DATA. Rising edge: sample qspi_i. Falling edge: drive next bits. SCLK idles low.
- FSM: IDLE -> CSSU -> CMD -> [ADDR if addr_en] -> [DUMMY if dummy>0] -> [DATA if nbytes>0] -> CSH -> DESEL -> IDLE.
- CSSU: csb low, one half-period, SCLK low; first command bit is driven at entry.
- CMD: 8 SCLK on IO0, MSB first; oe=4'b0001.
- ADDR: 24 SCLK on IO0, MSB first; oe=4'b0001.
- DUMMY: dummy_i SCLK cycles; oe=0000; qspi_o=0.
- DATA: bits/SCLK = 1/2/4 for single/dual/quad; MSB first.
  - Quad: IO[3:0] carries byte[7:4], then byte[3:0].
  - Dual: IO[1:0] carries bit pairs.
  - Single write drives IO0. Single read samples IO1.
  - Write: oe = 0001/0011/1111. Read: oe=0000.
- Write stream: tx_ready_o = tx_valid_i && engine needs next byte, at the start of each byte with SCLK low. If tx_valid_i=0, SCLK holds low and CSB stays low (stall) until valid. Exactly nbytes handshakes per transaction.
- Read stream: rx_valid_o pulses one cycle after the rising edge that samples the byte's last bits. No backpressure.
- CSH: after last falling edge, one half-period with CSB low. CSB then rises.
- DESEL: CSB high for two half-periods. Then done_o pulses, busy_o=0, FSM=IDLE in the same cycle. A start_i in that cycle is ignored.
- Byte and bit counters are sized LEN_W and 5 bits; no wrap for nbytes up to 2^LEN_W-1.
- clkdiv=0: SCLK = clk/2, legal.

Test Plan:
- WREN: cmd 0x06, no addr, dummy 0, nbytes 0, clkdiv 0 -> exactly 8 SCLK rising edges; IO0 sampled 0,0,0,0,0,1,1,0; no tx/rx strobes; one done_o pulse; CSB high afterwards.
- RDID: cmd 0x9F, single read, nbytes 3, flash model returns 0x20,0xBA,0x19, clkdiv 1 -> 32 SCLK edges; three rx_valid_o strobes carrying 0x20,0xBA,0x19; SCLK half-period = 2 clk; oe=0 during data.
- Quad read: cmd 0x6B, addr 0x123456, dummy 8, mode 2, nbytes 4 -> 8+24+8+8 SCLK edges; bytes assembled high nibble first; oe=0001 during cmd/addr, 0000 otherwise.
- Quad page program with stall: cmd 0x32, addr 0x000100, dir 1, nbytes 2, tx_valid dropped 10 cycles before byte 2 -> SCLK frozen low and CSB held low during stall; IO[3:0] shows 0xA,0x5 for byte 0xA5; exactly 2 tx_ready_o pulses.
- start_i during busy, plus async reset mid-ADDR -> second start ignored; on reset, CSB=1, SCLK=0, oe=0 immediately; a fresh transaction then completes normally.
